view_control_fsm: RTL
=====================

# view_control_fsm

Control FSM for the chess board view datapath. It sequences a full redraw: a 320×240 board background load, then 64 piece tiles of 28×28, fetching the piece code for each square from board memory before painting it. Between redraws it owns the flashing selection box around the chosen square. It sits between game logic (request side) and the view datapath/VGA adapter (strobe side).

## Interface
- FLASH_PERIOD, 12_500_000: cycles between selection-colour toggles (0.25 s at 50 MHz); must be ≥2
- MEM_LAT, 2: cycles from update_view/square entry until pieceFromMem is valid; must be ≥1
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; forces IDLE
- redraw_req  in  1  level; request full board + pieces redraw
- select_req  in  1  level; start flashing box at the datapath's current box_in_x/y
- select_clr  in  1  pulse; stop flashing and erase the box
- board_complete  in  1  datapath board sweep finished
- tile_complete  in  1  datapath 28×28 counter wrapped (clear_count28)
- ld_board  out  1  board sweep enable
- enable_count28  out  1  tile counter enable
- update_view  out  1  one-cycle pulse: advance view_x/view_y
- select  out  1  datapath colour mux selects colour_flash
- colour_flash  out  1  current box colour (1 = highlight, 0 = erase)
- plot  out  1  VGA write enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a redraw finishes

## Operation
- States: IDLE, LOAD_BOARD, PIECE_FETCH, PIECE_DRAW, PIECE_NEXT, SEL_DRAW, SEL_WAIT.
- Outputs are Moore and decoded from the state register only, except done, which is a registered pulse.
- IDLE:
  - redraw_req → LOAD_BOARD; sq_cnt←0.
  - Otherwise select_req → SEL_DRAW; colour_flash←1; clr_pend←0.
  - redraw_req wins when both are high. A select_req still high after the redraw is serviced next.
- LOAD_BOARD: ld_board=1, plot=1. When board_complete=1 → PIECE_FETCH; lat_cnt←0.
- PIECE_FETCH: all strobes 0. lat_cnt increments; at MEM_LAT−1 → PIECE_DRAW.
- PIECE_DRAW: enable_count28=1, plot=1. When tile_complete=1 → PIECE_NEXT.
- PIECE_NEXT (one cycle):
  - If sq_cnt=63 → IDLE, done=1 next cycle.
  - Else update_view=1, sq_cnt+1, → PIECE_FETCH.
  - sq_cnt is 6 bits and never wraps within a redraw.
- SEL_DRAW: select=1, enable_count28=1, plot=1 (the datapath masks to corner pixels). When tile_complete=1:
  - If clr_pend=1 and colour_flash=0 → IDLE.
  - Else → SEL_WAIT; flash_cnt←0.
- SEL_WAIT: all strobes 0; flash_cnt increments.
  - At FLASH_PERIOD−1: toggle colour_flash → SEL_DRAW.
  - select_clr → colour_flash←0, clr_pend←1, → SEL_DRAW (erase pass).
  - redraw_req (priority over the timer and select_clr) → LOAD_BOARD; colour_flash←0, clr_pend←0. The board reload erases the box.
- select_clr arriving during SEL_DRAW sets clr_pend. After that tile: force colour_flash←0, redraw once, then → IDLE.
- select_clr in any other state is ignored.
- Inputs in non-listening states are ignored: tile_complete outside PIECE_DRAW/SEL_DRAW, board_complete outside LOAD_BOARD.
- flash_cnt width is clog2(FLASH_PERIOD). lat_cnt width is clog2(MEM_LAT+1).

## Timing
- Reset values: state=IDLE; all outputs 0; sq_cnt, lat_cnt, flash_cnt, clr_pend = 0.
- reset mid-operation: IDLE on the next edge with all strobes low. The datapath is re-sequenced from scratch by the next request.
- Request sampled at edge N in IDLE → strobe asserted in cycle N+1.
- Per square: MEM_LAT + (tile cycles until tile_complete) + 1 cycle.
- update_view is high for exactly one cycle per square, 63 per redraw.
- done is high the cycle after the PIECE_NEXT that saw sq_cnt=63.
- Flash half-period = FLASH_PERIOD cycles in SEL_WAIT + SEL_DRAW duration.

## Structure
- Package view_ctrl_pkg holds:
  - state enum (3-bit encoding)
  - NUM_SQUARES=64
  - default FLASH_PERIOD and MEM_LAT constants
- Sub-module view_flash_timer: parameterised FLASH_PERIOD counter with clear/enable inputs and a terminal-count output. The FSM proper stays in view_control_fsm.

## Test plan
Bench uses a behavioural datapath: board_complete 5 cycles after ld_board rises; tile_complete 6 cycles after enable_count28 rises. Parameters: FLASH_PERIOD=4, MEM_LAT=2.
- Reset then idle → all outputs 0, busy=0 for 20 cycles.
- redraw_req pulse:
  - ld_board high 5 cycles.
  - Then 64 × (2 fetch + 6 draw + 1 next).
  - Exactly 63 update_view pulses.
  - done one cycle after the last tile; busy falls the same cycle.
- redraw_req and select_req both held:
  - Redraw runs first.
  - SEL_DRAW entered 1 cycle after IDLE, with colour_flash=1.
- Selection flashing:
  - colour_flash toggles every 4 SEL_WAIT cycles + 6 draw cycles.
  - select and plot high only during SEL_DRAW.
- select_clr in SEL_WAIT → one SEL_DRAW with colour_flash=0, then IDLE.
  - Same check with select_clr during SEL_DRAW: erase pass follows, then IDLE.
- redraw_req during SEL_WAIT → LOAD_BOARD next cycle, colour_flash=0.
  - Reset asserted mid-PIECE_DRAW → IDLE with all outputs 0 next cycle.

Source files
------------

// File: rtl/view_ctrl_pkg.sv
// rtl/view_ctrl_pkg.sv - shared types and constants for the chess board view controller
package view_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD_BOARD  = 3'd1,
    S_PIECE_FETCH = 3'd2,
    S_PIECE_DRAW  = 3'd3,
    S_PIECE_NEXT  = 3'd4,
    S_SEL_DRAW    = 3'd5,
    S_SEL_WAIT    = 3'd6
  } view_state_t;

  localparam int NUM_SQUARES          = 64;
  localparam int DEFAULT_FLASH_PERIOD = 12_500_000;
  localparam int DEFAULT_MEM_LAT      = 2;

endpackage

// File: rtl/view_flash_timer.sv
// rtl/view_flash_timer.sv - selection flash interval counter with clear, enable and terminal count
module view_flash_timer
  import view_ctrl_pkg::*;
#(
  parameter int FLASH_PERIOD = DEFAULT_FLASH_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = $clog2(FLASH_PERIOD);
  localparam logic [CW-1:0] TC_VAL = CW'(FLASH_PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = enable && (cnt == TC_VAL);

endmodule

// File: rtl/view_control_fsm.sv
// rtl/view_control_fsm.sv - redraw sequencer and selection-box flasher for the board view datapath
module view_control_fsm
  import view_ctrl_pkg::*;
#(
  parameter int FLASH_PERIOD = DEFAULT_FLASH_PERIOD,
  parameter int MEM_LAT      = DEFAULT_MEM_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic redraw_req,
  input  logic select_req,
  input  logic select_clr,
  input  logic board_complete,
  input  logic tile_complete,
  output logic ld_board,
  output logic enable_count28,
  output logic update_view,
  output logic select,
  output logic colour_flash,
  output logic plot,
  output logic busy,
  output logic done
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LAT - 1);
  localparam logic [5:0]    LAST_SQ  = 6'(NUM_SQUARES - 1);

  view_state_t   state, state_next;
  logic [5:0]    sq_cnt;
  logic [LW-1:0] lat_cnt;
  logic          clr_pend;
  logic          clr_eff;
  logic          flash_tc;

  // A clear seen on the completing cycle counts the same as one seen earlier in the pass.
  assign clr_eff = clr_pend || select_clr;

  view_flash_timer #(
    .FLASH_PERIOD(FLASH_PERIOD)
  ) u_flash_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state != S_SEL_WAIT),
    .enable(state == S_SEL_WAIT),
    .tc    (flash_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (redraw_req)      state_next = S_LOAD_BOARD;
        else if (select_req) state_next = S_SEL_DRAW;
      end
      S_LOAD_BOARD:  if (board_complete) state_next = S_PIECE_FETCH;
      S_PIECE_FETCH: if (lat_cnt == LAT_LAST) state_next = S_PIECE_DRAW;
      S_PIECE_DRAW:  if (tile_complete) state_next = S_PIECE_NEXT;
      S_PIECE_NEXT:  state_next = (sq_cnt == LAST_SQ) ? S_IDLE : S_PIECE_FETCH;
      S_SEL_DRAW: begin
        if (tile_complete) begin
          if (clr_eff && !colour_flash) state_next = S_IDLE;
          else if (clr_eff)             state_next = S_SEL_DRAW;
          else                          state_next = S_SEL_WAIT;
        end
      end
      S_SEL_WAIT: begin
        if (redraw_req)                  state_next = S_LOAD_BOARD;
        else if (select_clr || flash_tc) state_next = S_SEL_DRAW;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sq_cnt       <= '0;
      lat_cnt      <= '0;
      clr_pend     <= 1'b0;
      colour_flash <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= (state == S_PIECE_NEXT) && (sq_cnt == LAST_SQ);
      case (state)
        S_IDLE: begin
          if (redraw_req) begin
            sq_cnt <= '0;
          end else if (select_req) begin
            colour_flash <= 1'b1;
            clr_pend     <= 1'b0;
          end
        end
        S_LOAD_BOARD:  lat_cnt <= '0;
        S_PIECE_FETCH: lat_cnt <= lat_cnt + LW'(1);
        S_PIECE_NEXT: begin
          lat_cnt <= '0;
          if (sq_cnt != LAST_SQ) sq_cnt <= sq_cnt + 6'd1;
        end
        S_SEL_DRAW: begin
          if (select_clr) clr_pend <= 1'b1;
          if (tile_complete && clr_eff) colour_flash <= 1'b0;
        end
        S_SEL_WAIT: begin
          // The board reload paints over the box, so no erase pass is needed.
          if (redraw_req) begin
            colour_flash <= 1'b0;
            clr_pend     <= 1'b0;
            sq_cnt       <= '0;
          end else if (select_clr) begin
            colour_flash <= 1'b0;
            clr_pend     <= 1'b1;
          end else if (flash_tc) begin
            colour_flash <= ~colour_flash;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_board       = 1'b0;
    enable_count28 = 1'b0;
    update_view    = 1'b0;
    select         = 1'b0;
    plot           = 1'b0;
    busy           = (state != S_IDLE);
    case (state)
      S_LOAD_BOARD: begin
        ld_board = 1'b1;
        plot     = 1'b1;
      end
      S_PIECE_DRAW: begin
        enable_count28 = 1'b1;
        plot           = 1'b1;
      end
      S_PIECE_NEXT: update_view = (sq_cnt != LAST_SQ);
      S_SEL_DRAW: begin
        select         = 1'b1;
        enable_count28 = 1'b1;
        plot           = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
